z80fi_insn_collector: RTL and testbench

Upstream feeder for the z80fi instruction spec modules. It watches core-side fetch, write and retire strobes during one instruction. It assembles the instruction bytes and snapshots the IP and HL registers at instruction start. It captures the first memory write. On retire it presents one z80fi record for one cycle, with z80fi_valid high, to the spec/checker stage.

---
 rtl/z80fi_insn_collector.sv | 163 ++++++++++++++++
 tb/tb_z80fi_insn_collector.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/z80fi_insn_collector.sv
// Collects one instruction's fetch bytes, IP/HL at start and first memory write,
// then presents a single-cycle z80fi record on retire.
module z80fi_insn_collector #(
  parameter int MAX_LEN = 4,
  parameter int LEN_W   = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 insn_start,
  input  logic                 fetch_valid,
  input  logic [7:0]           fetch_data,
  input  logic [15:0]          reg_ip,
  input  logic [15:0]          reg_hl,
  input  logic                 mem_wr_valid,
  input  logic [15:0]          mem_wr_addr,
  input  logic [7:0]           mem_wr_data,
  input  logic                 retire,
  output logic                 z80fi_valid,
  output logic [8*MAX_LEN-1:0] z80fi_insn,
  output logic [LEN_W-1:0]     z80fi_insn_len,
  output logic [15:0]          z80fi_reg_ip_in,
  output logic [15:0]          z80fi_reg_hl_in,
  output logic                 z80fi_mem_wr,
  output logic [15:0]          z80fi_bus_waddr,
  output logic [7:0]           z80fi_bus_wdata,
  output logic                 z80fi_err
);

  // state   | meaning
  // IDLE    | no instruction in flight; waiting for a start byte
  // COLLECT | accumulating bytes/write of the current instruction
  typedef enum logic {IDLE, COLLECT} state_t;

  localparam int INSN_W = 8 * MAX_LEN;

  state_t state, state_nxt;

  logic [INSN_W-1:0] acc_insn, cur_insn, nxt_insn;
  logic [LEN_W-1:0]  acc_len, cur_len, nxt_len;
  logic [15:0]       acc_ip, acc_hl, nxt_ip, nxt_hl;
  logic              acc_wr, cur_wr, nxt_wr;
  logic [15:0]       acc_waddr, cur_waddr, nxt_waddr;
  logic [7:0]        acc_wdata, cur_wdata, nxt_wdata;
  logic              start_fetch, begin_new, rec_load, err_set;

  always_comb begin
    start_fetch = fetch_valid & insn_start;
    cur_insn    = acc_insn;
    cur_len     = acc_len;
    cur_wr      = acc_wr;
    cur_waddr   = acc_waddr;
    cur_wdata   = acc_wdata;
    err_set     = 1'b0;

    // Fold this cycle's fetch/write into the in-flight instruction; a start byte never belongs to it.
    if (state == COLLECT) begin
      if (fetch_valid && !insn_start) begin
        if (acc_len < LEN_W'(MAX_LEN)) begin
          for (int i = 0; i < MAX_LEN; i++) begin
            if (acc_len == LEN_W'(i)) cur_insn[8*i +: 8] = fetch_data;
          end
          cur_len = acc_len + LEN_W'(1);
        end else begin
          err_set = 1'b1;
        end
      end
      if (mem_wr_valid) begin
        if (!acc_wr) begin
          cur_wr    = 1'b1;
          cur_waddr = mem_wr_addr;
          cur_wdata = mem_wr_data;
        end else begin
          err_set = 1'b1;
        end
      end
    end

    state_nxt = state;
    rec_load  = 1'b0;
    begin_new = 1'b0;
    case (state)
      IDLE: begin
        if (start_fetch) begin
          begin_new = 1'b1;
          state_nxt = COLLECT;
        end else if (fetch_valid) begin
          err_set = 1'b1;
        end
      end
      COLLECT: begin
        if (retire) begin
          rec_load = 1'b1;
          if (start_fetch) begin_new = 1'b1;
          else             state_nxt = IDLE;
        end else if (start_fetch) begin
          begin_new = 1'b1;
          err_set   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    nxt_insn  = cur_insn;
    nxt_len   = cur_len;
    nxt_ip    = acc_ip;
    nxt_hl    = acc_hl;
    nxt_wr    = cur_wr;
    nxt_waddr = cur_waddr;
    nxt_wdata = cur_wdata;
    if (begin_new) begin
      nxt_insn  = INSN_W'(fetch_data);
      nxt_len   = LEN_W'(1);
      nxt_ip    = reg_ip;
      nxt_hl    = reg_hl;
      nxt_wr    = 1'b0;
      nxt_waddr = '0;
      nxt_wdata = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      acc_insn        <= '0;
      acc_len         <= '0;
      acc_ip          <= '0;
      acc_hl          <= '0;
      acc_wr          <= 1'b0;
      acc_waddr       <= '0;
      acc_wdata       <= '0;
      z80fi_valid     <= 1'b0;
      z80fi_insn      <= '0;
      z80fi_insn_len  <= '0;
      z80fi_reg_ip_in <= '0;
      z80fi_reg_hl_in <= '0;
      z80fi_mem_wr    <= 1'b0;
      z80fi_bus_waddr <= '0;
      z80fi_bus_wdata <= '0;
      z80fi_err       <= 1'b0;
    end else begin
      state       <= state_nxt;
      acc_insn    <= nxt_insn;
      acc_len     <= nxt_len;
      acc_ip      <= nxt_ip;
      acc_hl      <= nxt_hl;
      acc_wr      <= nxt_wr;
      acc_waddr   <= nxt_waddr;
      acc_wdata   <= nxt_wdata;
      z80fi_valid <= rec_load;
      z80fi_err   <= z80fi_err | err_set;
      if (rec_load) begin
        z80fi_insn      <= cur_insn;
        z80fi_insn_len  <= cur_len;
        z80fi_reg_ip_in <= acc_ip;
        z80fi_reg_hl_in <= acc_hl;
        z80fi_mem_wr    <= cur_wr;
        z80fi_bus_waddr <= cur_waddr;
        z80fi_bus_wdata <= cur_wdata;
      end
    end
  end

endmodule

// File: tb/tb_z80fi_insn_collector.sv
// Cycle-by-cycle directed vectors for z80fi_insn_collector: each row drives one
// cycle of core strobes and gives the record expected right after that edge.
module tb_z80fi_insn_collector;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        insn_start = 1'b0, fetch_valid = 1'b0, mem_wr_valid = 1'b0, retire = 1'b0;
  logic [7:0]  fetch_data = '0, mem_wr_data = '0;
  logic [15:0] reg_ip = '0, reg_hl = '0, mem_wr_addr = '0;
  logic        z80fi_valid, z80fi_mem_wr, z80fi_err;
  logic [31:0] z80fi_insn;
  logic [2:0]  z80fi_insn_len;
  logic [15:0] z80fi_reg_ip_in, z80fi_reg_hl_in, z80fi_bus_waddr;
  logic [7:0]  z80fi_bus_wdata;

  z80fi_insn_collector #(.MAX_LEN(4), .LEN_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .insn_start(insn_start), .fetch_valid(fetch_valid),
    .fetch_data(fetch_data), .reg_ip(reg_ip), .reg_hl(reg_hl), .mem_wr_valid(mem_wr_valid),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .retire(retire),
    .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
    .z80fi_reg_ip_in(z80fi_reg_ip_in), .z80fi_reg_hl_in(z80fi_reg_hl_in),
    .z80fi_mem_wr(z80fi_mem_wr), .z80fi_bus_waddr(z80fi_bus_waddr),
    .z80fi_bus_wdata(z80fi_bus_wdata), .z80fi_err(z80fi_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        st;
    logic        fv;
    logic [7:0]  fd;
    logic [15:0] ip;
    logic [15:0] hl;
    logic        wv;
    logic [15:0] wa;
    logic [7:0]  wd;
    logic        ret;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] insn;
    logic [2:0]  len;
    logic [15:0] ip;
    logic [15:0] hl;
    logic        wr;
    logic [15:0] wa;
    logic [7:0]  wd;
    logic        err;
  } rec_t;

  typedef struct packed {
    stim_t s;
    rec_t  e;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  function automatic rec_t actual();
    return '{z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_reg_ip_in, z80fi_reg_hl_in,
             z80fi_mem_wr, z80fi_bus_waddr, z80fi_bus_wdata, z80fi_err};
  endfunction

  task automatic compare(input string name, input rec_t exp_r);
    rec_t act;
    act = actual();
    checks++;
    if (act !== exp_r) begin
      failures++;
      $display("FAIL %s: got v=%0b insn=%h len=%0d ip=%h hl=%h wr=%0b wa=%h wd=%h err=%0b, want v=%0b insn=%h len=%0d ip=%h hl=%h wr=%0b wa=%h wd=%h err=%0b",
               name, act.valid, act.insn, act.len, act.ip, act.hl, act.wr, act.wa, act.wd, act.err,
               exp_r.valid, exp_r.insn, exp_r.len, exp_r.ip, exp_r.hl, exp_r.wr, exp_r.wa, exp_r.wd, exp_r.err);
    end
  endtask

  task automatic drive(input stim_t s);
    insn_start   = s.st;
    fetch_valid  = s.fv;
    fetch_data   = s.fd;
    reg_ip       = s.ip;
    reg_hl       = s.hl;
    mem_wr_valid = s.wv;
    mem_wr_addr  = s.wa;
    mem_wr_data  = s.wd;
    retire       = s.ret;
  endtask

  task automatic apply(input int idx);
    @(negedge clk);
    if (vecs[idx].s.rst) begin
      reset_n = 1'b0;
      #1 reset_n = 1'b1;
    end
    drive(vecs[idx].s);
    @(posedge clk);
    #1 compare($sformatf("row%0d", idx), vecs[idx].e);
  endtask

  task automatic add(input stim_t s, input rec_t e);
    vecs.push_back('{s, e});
  endtask

  localparam rec_t Z  = '0;
  localparam rec_t R1 = '{1'b1, 32'h00005A36, 3'd2, 16'h0100, 16'h1234, 1'b1, 16'h1234, 8'h5A, 1'b0};
  localparam rec_t R2 = '{1'b1, 32'h00000000, 3'd1, 16'h0102, 16'h4321, 1'b0, 16'h0000, 8'h00, 1'b0};
  localparam rec_t R3 = '{1'b1, 32'h0000773E, 3'd2, 16'h0300, 16'h0000, 1'b1, 16'h3000, 8'h99, 1'b0};
  localparam rec_t R4 = '{1'b1, 32'h7E0536DD, 3'd4, 16'h0400, 16'h0010, 1'b0, 16'h0000, 8'h00, 1'b1};
  localparam rec_t R5 = '{1'b1, 32'h00000077, 3'd1, 16'h0500, 16'h2000, 1'b1, 16'h2000, 8'h11, 1'b1};
  localparam rec_t R6 = '{1'b1, 32'h0000003C, 3'd1, 16'h0700, 16'h0001, 1'b0, 16'h0000, 8'h00, 1'b0};

  function automatic rec_t held(input rec_t r, input logic err);
    rec_t h;
    h       = r;
    h.valid = 1'b0;
    h.err   = err;
    return h;
  endfunction

  function automatic rec_t zero_err(input logic err);
    rec_t h;
    h     = '0;
    h.err = err;
    return h;
  endfunction

  initial begin
    // LD (HL),n then back-to-back NOP via retire coincident with start
    add('{0,1,1,8'h36,16'h0100,16'h1234,0,16'h0,8'h0,0}, Z);
    add('{0,0,1,8'h5A,16'h0,16'h0,0,16'h0,8'h0,0}, Z);
    add('{0,0,0,8'h00,16'h0,16'h0,1,16'h1234,8'h5A,0}, Z);
    add('{0,1,1,8'h00,16'h0102,16'h4321,0,16'h0,8'h0,1}, R1);
    add('{0,0,0,8'h00,16'h0,16'h0,0,16'h0,8'h0,1}, R2);
    add('{0,0,0,8'h00,16'h0,16'h0,0,16'h0,8'h0,0}, held(R2, 0));
    // fetch and write in the retire cycle belong to the retiring instruction
    add('{0,1,1,8'h3E,16'h0300,16'h0000,0,16'h0,8'h0,0}, held(R2, 0));
    add('{0,0,1,8'h77,16'h0,16'h0,1,16'h3000,8'h99,1}, R3);
    // overflow: fifth byte dropped, err set on that edge
    add('{0,1,1,8'hDD,16'h0400,16'h0010,0,16'h0,8'h0,0}, held(R3, 0));
    add('{0,0,1,8'h36,16'h0,16'h0,0,16'h0,8'h0,0}, held(R3, 0));
    add('{0,0,1,8'h05,16'h0,16'h0,0,16'h0,8'h0,0}, held(R3, 0));
    add('{0,0,1,8'h7E,16'h0,16'h0,0,16'h0,8'h0,0}, held(R3, 0));
    add('{0,0,1,8'h99,16'h0,16'h0,0,16'h0,8'h0,0}, held(R3, 1));
    add('{0,0,0,8'h00,16'h0,16'h0,0,16'h0,8'h0,1}, R4);
    // double write after a fresh reset: first capture kept
    add('{1,1,1,8'h77,16'h0500,16'h2000,0,16'h0,8'h0,0}, Z);
    add('{0,0,0,8'h00,16'h0,16'h0,1,16'h2000,8'h11,0}, Z);
    add('{0,0,0,8'h00,16'h0,16'h0,1,16'h2001,8'h22,0}, zero_err(1));
    add('{0,0,0,8'h00,16'h0,16'h0,0,16'h0,8'h0,1}, R5);
    // after mid-COLLECT async reset: retire in IDLE is ignored, clean instruction, IDLE noise
    add('{0,0,0,8'h00,16'h0,16'h0,0,16'h0,8'h0,1}, Z);
    add('{0,1,1,8'h3C,16'h0700,16'h0001,0,16'h0,8'h0,0}, Z);
    add('{0,0,0,8'h00,16'h0,16'h0,0,16'h0,8'h0,1}, R6);
    add('{0,0,0,8'h00,16'h0,16'h0,1,16'h5555,8'h66,1}, held(R6, 0));
    add('{0,0,1,8'hAA,16'h0,16'h0,0,16'h0,8'h0,0}, held(R6, 1));
    add('{0,0,0,8'h00,16'h0,16'h0,0,16'h0,8'h0,0}, held(R6, 1));

    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 compare("reset", Z);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i);
      if (i == 17) begin
        // start an instruction, then pull reset between edges
        @(negedge clk);
        drive('{0,1,1,8'h00,16'h0600,16'hBEEF,0,16'h0,8'h0,0});
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 compare("async_reset", Z);
        @(negedge clk);
        drive('0);
        reset_n = 1'b1;
      end
    end

    @(negedge clk);
    drive('0);
    repeat (2) @(posedge clk);
    #1 compare("final_idle", held(R6, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
